cordic_fsm_param: RTL and testbench

- Parametrised successor of the CORDIC control FSM for the floating-point sin/cos unit.
- Sequences N CORDIC iterations over variables X, Y and Z, and drives the shared add/subtract unit through a begin/ready/ack handshake.
- Generates every register enable and mux select in the datapath, and presents the result to the consumer through a ready/ACK handshake.
- Unlike the previous generation, it has internal iteration and variable counters, a runtime-configurable iteration count, and rotation/vectoring mode selection.

---
 rtl/cordic_fsm_pkg.sv | 11 +
 rtl/cordic_fsm_param_iter_counter.sv | 18 +
 rtl/cordic_fsm_param.sv | 110 +++++++++++
 tb/tb_cordic_fsm_param.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cordic_fsm_pkg.sv
// cordic_fsm_pkg: state encoding and variable/output select codes for the CORDIC control FSM
package cordic_fsm_pkg;
    typedef enum logic [3:0] {
        IDLE, LOAD, MUX, SHIFT, ADD_START, ADD_WAIT, ADD_ACK, ITER_END, OUT1, OUT2, DONE
    } state_t;
    localparam logic [1:0] VAR_X = 2'd0;
    localparam logic [1:0] VAR_Y = 2'd1;
    localparam logic [1:0] VAR_Z = 2'd2;
    localparam logic SEL_OUT_X = 1'b0;
    localparam logic SEL_OUT_Y = 1'b1;
endpackage

// File: rtl/cordic_fsm_param_iter_counter.sv
// cordic_iter_counter: clearable up-counter that wraps to zero after reaching its terminal value
module cordic_iter_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         max_tick,
    output logic         min_tick
);
    always_ff @(posedge clk)
        count <= (reset || load) ? '0 : enable ? (max_tick ? '0 : count + 1'b1) : count;
    assign max_tick = count == term;
    assign min_tick = count == '0;
endmodule

// File: rtl/cordic_fsm_param.sv
// cordic_fsm_param: CORDIC iteration sequencer with add/subtract and result handshakes
module cordic_fsm_param
    import cordic_fsm_pkg::*;
#(
    parameter int ITER_W = 5,
    parameter int N_ITER = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beg_FSM_CORDIC,
    input  logic              ACK_FSM_CORDIC,
    input  logic              operation,
    input  logic              mode_in,
    input  logic [1:0]        shift_region_flag,
    input  logic [ITER_W-1:0] n_iter_cfg,
    input  logic              ready_add_subt,
    output logic              ready_CORDIC,
    output logic              beg_add_subt,
    output logic              ack_add_subt,
    output logic              sel_mux_1,
    output logic [1:0]        sel_mux_2,
    output logic              sel_mux_3,
    output logic              mode,
    output logic [ITER_W-1:0] iter_idx,
    output logic              busy,
    output logic              enab_RB1,
    output logic              enab_RB2,
    output logic              enab_d_ff_Xn,
    output logic              enab_d_ff_Yn,
    output logic              enab_d_ff_Zn,
    output logic              enab_dff_shifted_x,
    output logic              enab_dff_shifted_y,
    output logic              enab_dff_LUT,
    output logic              enab_dff_sign,
    output logic              enab_dff5,
    output logic              enab_d_ff_out
);
    localparam logic [ITER_W:0]   NMAX  = (ITER_W+1)'(N_ITER);
    localparam logic [ITER_W-1:0] NLAST = ITER_W'(N_ITER - 1);
    state_t state, next;
    logic [ITER_W-1:0] iter_cnt, n_last;
    logic [1:0] var_cnt, region;
    logic i_max, i_min, v_max, v_min, clamp, sel_out, sel_q;
    cordic_iter_counter #(.W(ITER_W)) u_iter (
        .clk(clk), .reset(reset),
        .load(state == LOAD || (state == DONE && ACK_FSM_CORDIC)),
        .enable(state == ITER_END && !i_max), .term(n_last),
        .count(iter_cnt), .max_tick(i_max), .min_tick(i_min)
    );
    cordic_iter_counter #(.W(2)) u_var (
        .clk(clk), .reset(reset), .load(state == LOAD), .enable(state == ADD_ACK), .term(VAR_Z),
        .count(var_cnt), .max_tick(v_max), .min_tick(v_min)
    );
    assign clamp   = n_iter_cfg == '0 || {1'b0, n_iter_cfg} > NMAX;
    assign sel_out = (operation ^ (^region)) ? SEL_OUT_Y : SEL_OUT_X;
    always_ff @(posedge clk)
        state <= reset ? IDLE : next;
    always_ff @(posedge clk)
        if (reset) begin
            mode   <= 1'b0;
            region <= 2'b00;
            n_last <= '0;
            sel_q  <= SEL_OUT_X;
        end else begin
            if (state == LOAD) begin
                mode   <= mode_in;
                region <= shift_region_flag;
                n_last <= clamp ? NLAST : n_iter_cfg - 1'b1;
            end
            if (state == OUT1) sel_q <= sel_out;
        end
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = beg_FSM_CORDIC ? LOAD : IDLE;
            LOAD:      next = MUX;
            MUX:       next = SHIFT;
            SHIFT:     next = ADD_START;
            ADD_START: next = ADD_WAIT;
            ADD_WAIT:  next = ready_add_subt ? ADD_ACK : ADD_WAIT;
            ADD_ACK:   next = v_max ? ITER_END : ADD_START;
            ITER_END:  next = i_max ? OUT1 : MUX;
            OUT1:      next = OUT2;
            OUT2:      next = DONE;
            DONE:      next = ACK_FSM_CORDIC ? IDLE : DONE;
            default:   next = IDLE;
        endcase
    end
    always_comb begin
        ready_CORDIC       = state == DONE;
        beg_add_subt       = state == ADD_START;
        ack_add_subt       = state == ADD_ACK;
        sel_mux_1          = state == MUX && !i_min;
        sel_mux_2          = (state == ADD_START || state == ADD_WAIT) ? var_cnt : VAR_X;
        sel_mux_3          = state == OUT1 ? sel_out : (state == OUT2 || state == DONE) ? sel_q : SEL_OUT_X;
        iter_idx           = iter_cnt;
        busy               = state != IDLE;
        enab_RB1           = state == LOAD;
        enab_RB2           = state == MUX;
        enab_d_ff_Xn       = state == ADD_ACK && v_min;
        enab_d_ff_Yn       = state == ADD_ACK && var_cnt == VAR_Y;
        enab_d_ff_Zn       = state == ADD_ACK && v_max;
        enab_dff_shifted_x = state == SHIFT;
        enab_dff_shifted_y = state == SHIFT;
        enab_dff_LUT       = state == SHIFT;
        enab_dff_sign      = state == SHIFT;
        enab_dff5          = state == OUT1;
        enab_d_ff_out      = state == OUT2;
    end
endmodule

// File: tb/tb_cordic_fsm_param.sv
// tb_cordic_fsm_param: table-driven run vectors plus reset-mid-run sequence for cordic_fsm_param
module tb_cordic_fsm_param;
    logic clk = 1'b0;
    logic reset, beg, ack, operation, mode_in, ready_add_subt;
    logic [1:0] region;
    logic [4:0] n_iter_cfg;
    logic ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_3, mode, busy;
    logic [1:0] sel_mux_2;
    logic [4:0] iter_idx;
    logic enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
    logic enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign, enab_dff5, enab_d_ff_out;
    logic [24:0] all_out;
    int checks = 0, errors = 0, rsp_cnt = 0, rsp_w = 0;

    typedef struct {
        logic [4:0] cfg; logic op; logic [1:0] rg; logic md; int w;
        logic hold; logic early; logic tog; int n; int lat; logic sel;
    } vec_t;
    vec_t v[10];

    cordic_fsm_param dut (
        .clk(clk), .reset(reset), .beg_FSM_CORDIC(beg), .ACK_FSM_CORDIC(ack),
        .operation(operation), .mode_in(mode_in), .shift_region_flag(region),
        .n_iter_cfg(n_iter_cfg), .ready_add_subt(ready_add_subt),
        .ready_CORDIC(ready_CORDIC), .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
        .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2), .sel_mux_3(sel_mux_3), .mode(mode),
        .iter_idx(iter_idx), .busy(busy), .enab_RB1(enab_RB1), .enab_RB2(enab_RB2),
        .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
        .enab_dff_shifted_x(enab_dff_shifted_x), .enab_dff_shifted_y(enab_dff_shifted_y),
        .enab_dff_LUT(enab_dff_LUT), .enab_dff_sign(enab_dff_sign),
        .enab_dff5(enab_dff5), .enab_d_ff_out(enab_d_ff_out)
    );

    assign all_out = {ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_2, sel_mux_3,
                      mode, iter_idx, busy, enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn,
                      enab_d_ff_Zn, enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT,
                      enab_dff_sign, enab_dff5, enab_d_ff_out};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // advance one cycle, then model an adder whose result is valid after rsp_w wait cycles
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (beg_add_subt) rsp_cnt = 1;
        else if (ack_add_subt) rsp_cnt = 0;
        else if (rsp_cnt > 0) rsp_cnt++;
        ready_add_subt = (rsp_w == 0) || (rsp_cnt > rsp_w);
    endtask

    task automatic run_vec(input vec_t c, input string tag);
        int t, t_beg, k, mux_cnt, nb, na, ew;
        int gap_err, ord_err, iter_err, busy_err, mode_err, ack_err;
        logic prev_ack;
        logic [2:0] en, exp_en;
        t = 0; t_beg = 0; k = 0; mux_cnt = 0; nb = 0; na = 0; prev_ack = 1'b0;
        gap_err = 0; ord_err = 0; iter_err = 0; busy_err = 0; mode_err = 0; ack_err = 0;
        ew = (c.w == 0) ? 1 : c.w;
        rsp_w = c.w; rsp_cnt = 0; ready_add_subt = (c.w == 0);
        n_iter_cfg = c.cfg; operation = c.op; region = c.rg; mode_in = c.md; beg = 1'b1; ack = 1'b0;
        while (!ready_CORDIC && t < 2000) begin
            tick();
            t++;
            if (!c.hold) beg = 1'b0;
            if (t == 1) check({tag, " load_state"}, int'(enab_RB1), 1);
            if (c.tog && t >= 2) begin
                if (mode !== c.md) mode_err++;
                mode_in = ~mode_in;
            end
            ack = c.early && t == 20;
            if (!busy) busy_err++;
            if (beg_add_subt) begin nb++; t_beg = t; end
            if (ack_add_subt) begin
                na++;
                if (prev_ack) ack_err++;
                if (t - t_beg - 1 != ew) gap_err++;
            end
            prev_ack = ack_add_subt;
            en = {enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn};
            if (en != 3'b000) begin
                exp_en = 3'b100 >> (k % 3);
                if (en !== exp_en || !ack_add_subt) ord_err++;
                k++;
            end
            if (enab_RB2) begin
                if (iter_idx !== 5'(mux_cnt) || sel_mux_1 !== (mux_cnt != 0)) iter_err++;
                mux_cnt++;
            end
        end
        check({tag, " ready_latency"}, t, c.lat);
        check({tag, " beg_add_pulses"}, nb, 3 * c.n);
        check({tag, " ack_add_pulses"}, na, 3 * c.n);
        check({tag, " xyz_enables"}, k, 3 * c.n);
        check({tag, " iterations"}, mux_cnt, c.n);
        check({tag, " wait_len_errs"}, gap_err, 0);
        check({tag, " ack_width_errs"}, ack_err, 0);
        check({tag, " xyz_order_errs"}, ord_err, 0);
        check({tag, " iter_idx_errs"}, iter_err, 0);
        check({tag, " busy_errs"}, busy_err, 0);
        check({tag, " mode_errs"}, mode_err, 0);
        check({tag, " mode"}, int'(mode), int'(c.md));
        check({tag, " sel_mux_3"}, int'(sel_mux_3), int'(c.sel));
        tick();
        tick();
        check({tag, " done_held"}, int'({ready_CORDIC, sel_mux_3}), int'({1'b1, c.sel}));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        beg = 1'b0;
        check({tag, " idle_after_ack"}, int'({busy, ready_CORDIC, iter_idx}), 0);
        tick();
        tick();
        tick();
        check({tag, " no_restart"}, int'(busy), 0);
    endtask

    initial begin
        int t;
        logic found;
        v[0] = '{5'd4,  1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4,  52,  1'b0};
        v[1] = '{5'd4,  1'b0, 2'b00, 1'b0, 5, 1'b0, 1'b0, 1'b0, 4,  100, 1'b0};
        v[2] = '{5'd0,  1'b1, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0, 24, 292, 1'b0};
        v[3] = '{5'd31, 1'b0, 2'b10, 1'b0, 0, 1'b0, 1'b0, 1'b0, 24, 292, 1'b1};
        v[4] = '{5'd24, 1'b1, 2'b11, 1'b0, 0, 1'b0, 1'b0, 1'b0, 24, 292, 1'b1};
        v[5] = '{5'd1,  1'b1, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1,  16,  1'b1};
        v[6] = '{5'd2,  1'b0, 2'b00, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2,  28,  1'b0};
        v[7] = '{5'd3,  1'b0, 2'b01, 1'b1, 0, 1'b0, 1'b0, 1'b1, 3,  40,  1'b1};
        v[8] = '{5'd5,  1'b1, 2'b10, 1'b1, 2, 1'b0, 1'b0, 1'b0, 5,  79,  1'b0};
        v[9] = '{5'd23, 1'b0, 2'b11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 23, 280, 1'b0};
        reset = 1'b1; beg = 1'b0; ack = 1'b0; operation = 1'b0; mode_in = 1'b0;
        region = 2'b00; n_iter_cfg = 5'd0; ready_add_subt = 1'b0;
        tick();
        tick();
        tick();
        check("reset_outputs", int'(all_out), 0);
        reset = 1'b0;
        tick();
        check("idle_outputs", int'(all_out), 0);
        for (int i = 0; i < 10; i++) run_vec(v[i], $sformatf("v%0d", i));
        // stall in iteration 2 ADD_WAIT, then reset
        rsp_w = 2; rsp_cnt = 0; ready_add_subt = 1'b0;
        n_iter_cfg = 5'd4; operation = 1'b0; region = 2'b00; mode_in = 1'b1; beg = 1'b1;
        tick();
        beg = 1'b0;
        t = 0;
        found = 1'b0;
        while (!found && t < 500) begin
            tick();
            t++;
            if (beg_add_subt && iter_idx == 5'd2) found = 1'b1;
        end
        tick();
        check("pre_reset_iter", int'(iter_idx), 2);
        check("pre_reset_busy", int'({busy, ready_add_subt}), 2);
        reset = 1'b1;
        tick();
        check("reset_mid_outputs", int'(all_out), 0);
        reset = 1'b0;
        tick();
        run_vec(v[0], "after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
